// File: rtl/pb_inc_scheduler_pkg.sv
// Shared types for the push-button increment scheduler:
// channel FSM states and the round-robin pick helper.
package pb_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    WAIT_INIT,
    PULSE,
    WAIT_REP
  } ch_state_t;

  localparam int MAX_CH = 32;
  localparam int IDX_W  = 5;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req[0..n-1], searching from ptr and wrapping.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_CH-1:0] req,
    input int                n,
    input int                ptr
  );
    rr_pick_t r;
    int       j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (!r.found && req[j[IDX_W-1:0]]) begin
          r.found = 1'b1;
          r.idx   = j[IDX_W-1:0];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pb_inc_scheduler_if.sv
// Button-status / increment-command bundle.
// master = scheduler side, slave = buttons + datapath side.
interface pb_inc_scheduler_if #(
  parameter int N_CH = 4,
  parameter int CH_W = $clog2(N_CH)
);
  logic [N_CH-1:0] pressed_status;
  logic            inc_valid;
  logic [CH_W-1:0] inc_ch;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] drop_sticky;

  modport master (
    input  pressed_status,
    output inc_valid, inc_ch, pending, drop_sticky
  );

  modport slave (
    output pressed_status,
    input  inc_valid, inc_ch, pending, drop_sticky
  );
endinterface

// File: rtl/pb_inc_scheduler_channel.sv
// Per-button auto-repeat timer.
// Ports: clk, rst, pressed_i (held level), ch_pulse_o (pulse request).
module pb_repeat_channel
  import pb_sched_pkg::*;
#(
  parameter int N_INITIAL_DELAY = 10,
  parameter int N_REPEAT_DELAY  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed_i,
  output logic ch_pulse_o
);
  localparam int T_W = $clog2(N_INITIAL_DELAY);
  localparam logic [T_W-1:0] T_INIT_END =
    T_W'(N_INITIAL_DELAY - 2);
  localparam logic [T_W-1:0] T_REP_END =
    T_W'(N_REPEAT_DELAY - 2);

  ch_state_t      state_q, state_d;
  logic [T_W-1:0] t_q, t_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  // Wait states run N-1 cycles so pulse spacing is exactly N.
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    ch_pulse_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pressed_i) state_d = FIRST;
      end
      FIRST: begin
        ch_pulse_o = 1'b1;
        t_d        = '0;
        state_d    = pressed_i ? WAIT_INIT : IDLE;
      end
      WAIT_INIT: begin
        t_d = t_q + 1'b1;
        if (!pressed_i)             state_d = IDLE;
        else if (t_q == T_INIT_END) state_d = PULSE;
      end
      PULSE: begin
        ch_pulse_o = 1'b1;
        t_d        = '0;
        state_d    = pressed_i ? WAIT_REP : IDLE;
      end
      WAIT_REP: begin
        t_d = t_q + 1'b1;
        if (!pressed_i)            state_d = IDLE;
        else if (t_q == T_REP_END) state_d = PULSE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/pb_inc_scheduler.sv
// Shares one increment command port between N_CH auto-repeat buttons.
// Ports: clk, rst, bus (pressed_status in; inc_valid/inc_ch/pending/drop_sticky out).
module pb_inc_scheduler
  import pb_sched_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int N_INITIAL_DELAY = 10,
  parameter int N_REPEAT_DELAY  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pb_inc_scheduler_if.master   bus
);
  localparam int CH_W = $clog2(N_CH);

  logic [N_CH-1:0]   ch_pulse;
  logic [N_CH-1:0]   grant;
  logic [N_CH-1:0]   pending_q, pending_d;
  logic [N_CH-1:0]   drop_q, drop_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   inc_ch_q, inc_ch_d;
  logic              inc_valid_q, inc_valid_d;
  logic [MAX_CH-1:0] req_ext;
  rr_pick_t          pick;
  int                nxt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pb_repeat_channel #(
      .N_INITIAL_DELAY (N_INITIAL_DELAY),
      .N_REPEAT_DELAY  (N_REPEAT_DELAY)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pressed_i  (bus.pressed_status[g]),
      .ch_pulse_o (ch_pulse[g])
    );
  end

  always_comb begin
    req_ext           = '0;
    req_ext[N_CH-1:0] = pending_q;
    pick     = rr_pick(req_ext, N_CH, int'(rr_ptr_q));
    grant    = '0;
    rr_ptr_d = rr_ptr_q;
    nxt      = 0;
    if (pick.found) begin
      grant[pick.idx[CH_W-1:0]] = 1'b1;
      nxt = int'(pick.idx) + 1;
      if (nxt >= N_CH) nxt = 0;
      rr_ptr_d = nxt[CH_W-1:0];
    end
    // A pulse landing on a granted slot refills it; only an
    // ungranted occupied slot loses the new pulse.
    pending_d   = ch_pulse | (pending_q & ~grant);
    drop_d      = drop_q | (ch_pulse & pending_q & ~grant);
    inc_valid_d = |pending_q;
    inc_ch_d    = pick.idx[CH_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      drop_q      <= '0;
      rr_ptr_q    <= '0;
      inc_valid_q <= 1'b0;
      inc_ch_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      drop_q      <= drop_d;
      rr_ptr_q    <= rr_ptr_d;
      inc_valid_q <= inc_valid_d;
      inc_ch_q    <= inc_ch_d;
    end
  end

  assign bus.inc_valid   = inc_valid_q;
  assign bus.inc_ch      = inc_ch_q;
  assign bus.pending     = pending_q;
  assign bus.drop_sticky = drop_q;
endmodule
